// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with a line-fill burst engine.
// Build with ICACHE_STATS_EN defined to add the hit/miss counter outputs.
module icache_dm #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rd,
  input  logic [31:0] i_addr,
  input  logic        i_inval,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] o_hit_cnt,
  output logic [31:0] o_miss_cnt
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             unused_addr_lsbs;

  assign req_off          = i_addr[OFF_W+1:2];
  assign req_idx          = i_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign req_tag          = i_addr[31:OFF_W+IDX_W+2];
  assign unused_addr_lsbs = ^i_addr[1:0];

  // NOTE: the data and tag arrays are deliberately not reset; the per-line
  // valid flops are the only state that must be cleared for correctness.
  logic [31:0]      data_mem [SETS*LINE_WORDS];
  logic [TAG_W-1:0] tag_mem  [SETS];

  logic [0:0]       state_q,     state_d;
  logic [SETS-1:0]  valid_q,     valid_d;
  logic [OFF_W-1:0] cnt_q,       cnt_d;
  logic [IDX_W-1:0] fill_idx_q,  fill_idx_d;
  logic [TAG_W-1:0] fill_tag_q,  fill_tag_d;
  logic             drop_q,      drop_d;
  logic [31:0]      data_q,      data_d;
  logic             out_valid_q, out_valid_d;
  logic             mem_req_q,   mem_req_d;
  logic [31:0]      mem_addr_q,  mem_addr_d;

  logic lookup_hit;
  logic data_we;
  logic tag_we;

  // An invalidate in the lookup cycle forces a miss even if the line was valid.
  assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag) && !i_inval;

  // NOTE: every signal gets a default at the top of the block so that no
  // path through the case statement can leave it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    fill_idx_d  = fill_idx_q;
    fill_tag_d  = fill_tag_q;
    drop_d      = drop_q;
    data_d      = data_q;
    out_valid_d = 1'b0;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    data_we     = 1'b0;
    tag_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_inval) begin
          valid_d = '0;
        end
        if (i_rd && lookup_hit) begin
          data_d      = data_mem[{req_idx, req_off}];
          out_valid_d = 1'b1;
        end else if (i_rd) begin
          fill_idx_d = req_idx;
          fill_tag_d = req_tag;
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
          state_d    = ST_FILL;
        end
      end

      default: begin
        if (i_inval) begin
          valid_d = '0;
          drop_d  = 1'b1;
        end
        if (i_mem_ack) begin
          data_we    = 1'b1;
          cnt_d      = cnt_q + OFF_W'(1);
          mem_addr_d = mem_addr_q + 32'd4;
          if (&cnt_q) begin
            tag_we = 1'b1;
            // A line invalidated while in flight is written but left invalid.
            if (!drop_q && !i_inval) begin
              valid_d[fill_idx_q] = 1'b1;
            end
            mem_req_d = 1'b0;
            drop_d    = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      valid_q     <= '0;
      cnt_q       <= '0;
      fill_idx_q  <= '0;
      fill_tag_q  <= '0;
      drop_q      <= 1'b0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      fill_idx_q  <= fill_idx_d;
      fill_tag_q  <= fill_tag_d;
      drop_q      <= drop_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (data_we) begin
      data_mem[{fill_idx_q, cnt_q}] <= i_mem_data;
    end
    if (tag_we) begin
      tag_mem[fill_idx_q] <= fill_tag_q;
    end
  end

  assign o_data     = data_q;
  assign o_valid    = out_valid_q;
  assign o_mem_req  = mem_req_q;
  assign o_mem_addr = mem_addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q,  hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Counters wrap naturally at 32 bits.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == ST_IDLE && i_rd) begin
      if (lookup_hit) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign o_hit_cnt  = hit_cnt_q;
  assign o_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm (SETS=64, LINE_WORDS=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_icache_dm;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_rd;
  logic [31:0] i_addr;
  logic        i_inval;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] o_hit_cnt;
  logic [31:0] o_miss_cnt;
`endif

  int tests;
  int fails;

  icache_dm #(.SETS(64), .LINE_WORDS(4)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rd       (i_rd),
    .i_addr     (i_addr),
    .i_inval    (i_inval),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_mem_req  (o_mem_req),
    .o_mem_addr (o_mem_addr),
    .i_mem_ack  (i_mem_ack),
    .i_mem_data (i_mem_data)
`ifdef ICACHE_STATS_EN
    ,
    .o_hit_cnt  (o_hit_cnt),
    .o_miss_cnt (o_miss_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  // Present an address and expect the cache to start a burst at its line base.
  task automatic expect_miss(input logic [31:0] addr);
    i_rd   = 1'b1;
    i_addr = addr;
    step();
    check(o_mem_req, 1, "miss_req");
    check(o_mem_addr, {addr[31:4], 4'h0}, "miss_base");
    check(o_valid, 0, "miss_valid");
  endtask

  task automatic expect_hit(input logic [31:0] addr, input logic [31:0] data);
    i_rd   = 1'b1;
    i_addr = addr;
    step();
    check(o_valid, 1, "hit_valid");
    check(o_data, data, "hit_data");
    check(o_mem_req, 0, "hit_req");
  endtask

  // Memory model: ack nacks words of the line at base with data d0+w,
  // gap idle cycles before each ack, i_inval pulsed with ack number inval_at.
  task automatic fill(input logic [31:0] base, input logic [31:0] d0,
                      input int nacks, input int gap, input int inval_at);
    for (int w = 0; w < nacks; w++) begin
      for (int g = 0; g < gap; g++) begin
        check(o_mem_req, 1, "fill_wait_req");
        check(o_mem_addr, base + 32'(4 * w), "fill_wait_addr");
        step();
      end
      check(o_mem_req, 1, "fill_req");
      check(o_mem_addr, base + 32'(4 * w), "fill_addr");
      check(o_valid, 0, "fill_valid");
      i_mem_ack  = 1'b1;
      i_mem_data = d0 + 32'(w);
      i_inval    = (w == inval_at);
      step();
      i_mem_ack  = 1'b0;
      i_inval    = 1'b0;
    end
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    i_rst_n    = 1'b0;
    i_rd       = 1'b0;
    i_addr     = '0;
    i_inval    = 1'b0;
    i_mem_ack  = 1'b0;
    i_mem_data = '0;

    // Reset state
    step();
    step();
    check(o_valid, 0, "rst_valid");
    check(o_data, 0, "rst_data");
    check(o_mem_req, 0, "rst_req");
    check(o_mem_addr, 0, "rst_mem_addr");
`ifdef ICACHE_STATS_EN
    check(o_hit_cnt, 0, "rst_hit_cnt");
    check(o_miss_cnt, 0, "rst_miss_cnt");
`endif
    i_rst_n = 1'b1;
    step();

    // Cold miss with back-to-back acks, then re-lookup hit two cycles later
    expect_miss(32'h100);
    fill(32'h100, 32'hA0, 4, 0, -1);
    check(o_mem_req, 0, "cold_done_req");
    check(o_valid, 0, "cold_done_valid");
    expect_hit(32'h100, 32'hA0);

    // Sequential hits
    expect_hit(32'h104, 32'hA1);
    expect_hit(32'h108, 32'hA2);
    expect_hit(32'h10C, 32'hA3);
`ifdef ICACHE_STATS_EN
    check(o_hit_cnt, 4, "seq_hit_cnt");
    check(o_miss_cnt, 1, "seq_miss_cnt");
`endif

    // No request: output goes invalid
    i_rd = 1'b0;
    step();
    check(o_valid, 0, "idle_valid");
    check(o_mem_req, 0, "idle_req");

    // Conflict miss on the same index evicts the resident line
    expect_miss(32'h1100);
    fill(32'h1100, 32'hB0, 4, 0, -1);
    expect_hit(32'h1100, 32'hB0);
    expect_miss(32'h100);

    // Slow memory refill of 0x100, three idle cycles before each ack
    fill(32'h100, 32'hC0, 4, 3, -1);
    expect_hit(32'h100, 32'hC0);
    expect_hit(32'h104, 32'hC1);
    expect_hit(32'h108, 32'hC2);
    expect_hit(32'h10C, 32'hC3);

    // Invalidate during fill: burst completes, re-lookup misses again
    expect_miss(32'h200);
    fill(32'h200, 32'hD0, 4, 0, 1);
    check(o_mem_req, 0, "drop_done_req");
    expect_miss(32'h200);
    fill(32'h200, 32'hD0, 4, 0, -1);
    expect_hit(32'h200, 32'hD0);

    // Invalidate in IDLE turns a same-cycle lookup into a miss
    i_inval = 1'b1;
    step();
    i_inval = 1'b0;
    check(o_mem_req, 1, "inval_idle_req");
    check(o_mem_addr, 32'h200, "inval_idle_addr");
    check(o_valid, 0, "inval_idle_valid");
    fill(32'h200, 32'hE0, 4, 0, -1);
    expect_hit(32'h204, 32'hE1);

    // Asynchronous reset between the 2nd and 3rd ack
    expect_miss(32'h300);
    fill(32'h300, 32'hF0, 2, 0, -1);
    check(o_mem_req, 1, "mid_fill_req");
    check(o_mem_addr, 32'h308, "mid_fill_addr");
    #2 i_rst_n = 1'b0;
    #1;
    check(o_mem_req, 0, "async_rst_req");
    check(o_valid, 0, "async_rst_valid");
    check(o_mem_addr, 0, "async_rst_addr");
`ifdef ICACHE_STATS_EN
    check(o_hit_cnt, 0, "async_rst_hit_cnt");
    check(o_miss_cnt, 0, "async_rst_miss_cnt");
`endif
    step();
    i_rst_n = 1'b1;
    expect_miss(32'h300);
    fill(32'h300, 32'hF0, 4, 0, -1);
    expect_hit(32'h30C, 32'hF3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch port and a word-wide backing memory.
- CPU side: the CPU drives a byte fetch address and stalls while the cache's valid output is low.
- On a miss, the cache runs a line-fill burst to memory and then re-looks up the address.
- It is the stage that feeds the CPU's instruction data-in and instruction-valid inputs.

Parameters:
- SETS, 64, number of lines; power of two, at least 2.
- LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rd  in  1  fetch request this cycle.
- i_addr  in  32  CPU fetch byte address; bits [1:0] ignored.
- i_inval  in  1  invalidate all lines (fence.i).
- o_data  out  32  instruction word.
- o_valid  out  1  o_data valid for the address presented the previous cycle.
- o_mem_req  out  1  burst read request to backing memory.
- o_mem_addr  out  32  word-aligned backing memory address.
- i_mem_ack  in  1  i_mem_data valid this cycle.
- i_mem_data  in  32  backing memory read word.

Behaviour:
- Address split:
  - OFF = log2(LINE_WORDS) bits at [OFF+1:2].
  - IDX = log2(SETS) bits above OFF.
  - TAG = remaining upper bits.
- Storage:
  - Data array SETS*LINE_WORDS words; no reset.
  - Tag array; no reset.
  - Valid bit per line, held in flops.
- Reset (async, on i_rst_n low):
  - State IDLE; all valid bits 0.
  - o_valid 0, o_data 0, o_mem_req 0, o_mem_addr 0, fill counter 0.
- IDLE state:
  - Hit = valid[IDX] and tag[IDX]==TAG.
  - i_rd and hit: next edge o_data<=word[IDX][OFF], o_valid<=1. One-cycle latency; back-to-back hits give o_valid 1 every cycle.
  - i_rd and miss: o_valid<=0; latch line base {TAG,IDX,0..0}; counter<=0; o_mem_req<=1; o_mem_addr<=line base; go to FILL.
  - i_rd low: o_valid<=0.
- FILL state:
  - o_valid is held at 0.
  - o_mem_req stays 1 until the last word is acked.
  - Each i_mem_ack writes i_mem_data to word[IDX][counter], then counter+1 and o_mem_addr+4.
  - Ack of word LINE_WORDS-1: write the tag; set valid unless invalidated during this fill; o_mem_req<=0; go to IDLE.
  - No re-request: the following cycle re-looks up the current i_addr, which hits unless the address changed or the line was invalidated.
- Burst order: always word 0 upward, no critical-word-first. Wrap is not needed since the burst never crosses a line.
- Memory handshake:
  - Memory may ack on any cycle o_mem_req=1, including consecutive cycles.
  - o_mem_addr is stable between acks.
  - Unbounded wait is allowed.
- i_addr change during FILL: the fill completes for the latched line regardless; lookup resumes with the new address.
- i_inval:
  - In IDLE it clears all valid bits at the edge, and a lookup in the same cycle is treated as a miss.
  - During FILL it clears all valid bits and sets a drop flag so the in-flight line finishes invalid. The flag clears on return to IDLE.
- Reset mid-FILL: the burst is abandoned, o_mem_req drops immediately, all lines are invalid.
- Conflict miss (same IDX, different TAG): the line is overwritten.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined: adds outputs o_hit_cnt[31:0] and o_miss_cnt[31:0], both async-reset to 0.
  - Hit counter increments on each IDLE cycle with i_rd and hit.
  - Miss counter increments on each IDLE to FILL transition.
  - Both wrap 0xFFFFFFFF to 0; re-lookup hits after a fill count as hits.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: reset, then i_rd=1, i_addr=0x100; memory acks each cycle with data 0xA0,0xA1,0xA2,0xA3.
  - Required: o_mem_addr=0x100,0x104,0x108,0x10C; o_valid=0 throughout; o_valid=1 with o_data=0xA0 two cycles after the last ack.
- Sequential hits:
  - Stimulus: after the fill, i_addr steps 0x104, 0x108, 0x10C on consecutive cycles.
  - Required: o_valid=1 every cycle, o_data 0xA1, 0xA2, 0xA3; o_mem_req stays 0.
- Conflict:
  - Stimulus: with 0x100 resident, fetch 0x1100 (same index, SETS=64, LINE_WORDS=4).
  - Required: a fill burst from 0x1100; a subsequent fetch of 0x100 misses again.
- Slow memory:
  - Stimulus: acks spaced 3 idle cycles apart.
  - Required: o_mem_addr holds each value until its ack; the fill still yields the correct 4 words.
- Invalidate during fill:
  - Stimulus: i_inval pulsed in the cycle of the second ack.
  - Required: the burst completes (4 acks), then the re-lookup of the same address misses and starts a new burst.
- Async reset mid-fill:
  - Stimulus: drop i_rst_n between the 2nd and 3rd ack.
  - Required: o_mem_req=0 and o_valid=0 immediately without a clock edge; the next fetch of the same line misses.
  - With ICACHE_STATS_EN defined: the counters read 0.
